posit_denorm_arbiter: RTL and testbench
=======================================

# posit_denorm_arbiter

Round-robin arbiter that shares one downstream posit normalize/round unit between `NUM_REQ` producers of denormalized posit words (sign, inf, zero, scale, fraction). Each requester presents a word on a valid/ready channel. The arbiter grants one requester per cycle and canonicalizes special values. It delivers the word through a single registered output stage, tagged with the requester ID, to the normalizer input. It sits between the parallel posit arithmetic lanes (adders, multipliers, accumulators) and the single shared normalizer.

## Interface
Parameters:
- `POSIT_WIDTH`, default 8: posit word width.
- `POSIT_ES`, default 0: exponent size.
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `SCALE_W` (derived): scale width, from the posit_defines scale-width rule for (`POSIT_WIDTH`, `POSIT_ES`, 0).
- `FRAC_W` (derived): fraction width, from the posit_defines fraction-width rule for (`POSIT_WIDTH`, `POSIT_ES`, 0).
- `D_W` (derived): 3+`SCALE_W`+`FRAC_W`. Packed word, MSB→LSB: sign, inf, zero, scale, fraction.
- `ID_W` (derived): max(1, clog2(`NUM_REQ`)).

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid` input `NUM_REQ`: per-requester valid.
- `req_data` input `NUM_REQ`*`D_W`: requester i occupies bits [i*`D_W` +: `D_W`].
- `req_last` input `NUM_REQ`: end-of-burst marker. Used only when the burst-lock feature is compiled in.
- `req_ready` output `NUM_REQ`: per-requester ready.
- `out_valid` output 1: output word valid.
- `out_data` output `D_W`: canonicalized denormalized word.
- `out_id` output `ID_W`: index of the granting requester.
- `out_ready` input 1: downstream ready.

## Operation
- Beat transfer: requester i transfers when `req_valid[i]` && `req_ready[i]`. Output transfers when `out_valid` && `out_ready`.
- Output register load enable: `load` = !`out_valid` || `out_ready`.
- Grant: combinational, one-hot. Selects the first asserted `req_valid` at or after pointer `rr_ptr`, wrapping modulo `NUM_REQ`. No valid requester means no grant.
- `req_ready[i]` = `grant[i]` && `load`. At most one `req_ready` bit is high in any cycle.
- `rr_ptr` update: on an accepted beat from requester g, `rr_ptr` ← (g+1) mod `NUM_REQ`. No change without an accepted beat.
- Output register on `load`:
  - If a grant exists: `out_valid` ← 1, `out_id` ← g, `out_data` ← canon(`req_data[g]`).
  - Otherwise: `out_valid` ← 0, and `out_data`/`out_id` hold their previous values.
- canon(w):
  - If inf=1: emit sign=0, inf=1, zero=0, scale=0, fraction=0 (NaR). inf takes priority when inf and zero are both set.
  - Else if zero=1: emit all fields 0 except zero=1.
  - Otherwise w passes unchanged.
- Requesters must hold `req_valid`/`req_data` stable until accepted. The arbiter does not check this.

## Timing
- Latency: 1 cycle from accepted input beat to `out_valid`.
- Throughput: 1 beat per cycle while `out_ready`=1.
- Backpressure: `out_ready`=0 with `out_valid`=1 holds `out_data`/`out_id` stable and drives all `req_ready` low.
- Reset (asynchronous assert, synchronous-safe deassert): `out_valid`=0, `out_data`=0, `out_id`=0, `rr_ptr`=0, burst state IDLE, `req_ready` all 0 in the reset cycle.
- Reset mid-operation drops any word held in the output register. There is no recovery.
- Simultaneous requests: requester `rr_ptr` has priority, then ascending indices with wrap. N continuous requesters each receive exactly 1 beat in every N accepted beats.
- A new request arriving in the same cycle as an output transfer can be accepted that cycle, giving back-to-back transfers.

## Configuration
- Macro: `POSIT_DENORM_ARB_BURST_LOCK_EN`.
- Defined:
  - State machine IDLE/LOCKED plus register `lock_id`.
  - In IDLE, an accepted beat with `req_last[g]`=0 moves to LOCKED, sets `lock_id`=g, and leaves `rr_ptr` unchanged.
  - In LOCKED, the grant goes only to `lock_id`. Other requests are ignored even if `lock_id` deasserts valid.
  - An accepted beat with `req_last`=1 returns to IDLE and sets `rr_ptr` ← (`lock_id`+1) mod `NUM_REQ`.
  - A single-beat burst (`req_last`=1 in IDLE) behaves as the undefined case.
- Undefined: `req_last` is ignored, there is no LOCKED state, and arbitration is per beat.

## Test plan
- Reset, then `req_valid`=4'b1111 with `out_ready`=1 for 8 cycles → `out_id` sequence 0,1,2,3,0,1,2,3, first `out_valid` one cycle after the first accept.
- Only requester 2 valid, `out_ready` held low for 3 cycles after the first accept → `out_data`/`out_id`=2 stable and `req_ready`=0 throughout; the second beat is accepted in the cycle `out_ready` rises.
- Word with inf=1, zero=1, sign=1, scale=5, fraction=0x3 → output inf=1, zero=0, sign=0, scale=0, fraction=0. Word with zero=1, sign=1 → output zero=1, all other fields 0.
- Assert `rst_n`=0 while `out_valid`=1 → `out_valid`=0 immediately. After release, requesters 1 and 3 both valid → requester 1 is granted first (`rr_ptr`=0).
- `POSIT_DENORM_ARB_BURST_LOCK_EN`: requester 1 sends 3 beats with `req_last`=0,0,1 while requester 0 is continuously valid → `out_id`=1,1,1, then 0. Requester 0 is not granted during the burst, even in a cycle where requester 1 deasserts valid.
- `NUM_REQ`=2: both requesters valid for 6 beats → `out_id` alternates 0,1,0,1,0,1, and `ID_W`=1.

Source files
------------

// File: rtl/posit_denorm_arbiter_if.sv
`default_nettype none
// posit_denorm_arbiter_if: requester-side and normalizer-side channels of the
// posit denorm arbiter, with field widths derived from the posit format.
interface posit_denorm_arbiter_if #(
  parameter int POSIT_WIDTH = 8,
  parameter int POSIT_ES    = 0,
  parameter int NUM_REQ     = 4
);
  localparam int SCALE_W = $clog2(POSIT_WIDTH) + POSIT_ES + 1;
  localparam int FRAC_W  = (POSIT_WIDTH - POSIT_ES - 3 > 1) ? (POSIT_WIDTH - POSIT_ES - 3) : 1;
  localparam int D_W     = 3 + SCALE_W + FRAC_W;
  localparam int ID_W    = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*D_W-1:0] req_data;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   out_valid;
  logic [D_W-1:0]         out_data;
  logic [ID_W-1:0]        out_id;
  logic                   out_ready;

  // Producer lanes plus downstream normalizer, seen from outside the arbiter.
  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface
`default_nettype wire

// File: rtl/posit_denorm_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// posit_denorm_arbiter: round-robin arbiter sharing one posit normalizer among
// NUM_REQ producers; canonicalizes NaR/zero words into a registered output.
// Optional burst lock: define POSIT_DENORM_ARB_BURST_LOCK_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module posit_denorm_arbiter #(
  parameter int POSIT_WIDTH = 8,
  parameter int POSIT_ES    = 0,
  parameter int NUM_REQ     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  posit_denorm_arbiter_if.slave bus
);
  localparam int SCALE_W  = $clog2(POSIT_WIDTH) + POSIT_ES + 1;
  localparam int FRAC_W   = (POSIT_WIDTH - POSIT_ES - 3 > 1) ? (POSIT_WIDTH - POSIT_ES - 3) : 1;
  localparam int D_W      = 3 + SCALE_W + FRAC_W;
  localparam int ID_W     = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
  localparam int INF_BIT  = D_W - 2;
  localparam int ZERO_BIT = D_W - 3;

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic                 grant_any;
  logic [ID_W-1:0]      grant_id;
  logic [2*NUM_REQ-1:0] elig_dbl;
  logic [NUM_REQ-1:0]   elig_rot;
  logic [ID_W:0]        offset;
  logic [ID_W:0]        grant_sum;
  logic [D_W-1:0]       sel_word;
  logic                 load;
  logic                 accept;
  logic                 ptr_adv;
  logic                 out_valid_q;
  logic [D_W-1:0]       out_data_q;
  logic [ID_W-1:0]      out_id_q;

  // NaR wins over zero; both collapse every other field to 0.
  function automatic logic [D_W-1:0] canon(input logic [D_W-1:0] w);
    logic [D_W-1:0] c;
    c = w;
    if (w[INF_BIT]) begin
      c          = '0;
      c[INF_BIT] = 1'b1;
    end else if (w[ZERO_BIT]) begin
      c           = '0;
      c[ZERO_BIT] = 1'b1;
    end
    return c;
  endfunction

  // Rotate the eligible vector so rr_ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    elig_dbl  = {eligible, eligible} >> rr_ptr;
    elig_rot  = elig_dbl[NUM_REQ-1:0];
    grant_any = |elig_rot;
    offset    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig_rot[k]) offset = (ID_W+1)'(k);
    end
    grant_sum = {1'b0, rr_ptr} + offset;
    if (grant_sum >= NUM_REQ_W) grant_sum = grant_sum - NUM_REQ_W;
    grant_id = grant_sum[ID_W-1:0];
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_grant
    assign grant[i] = grant_any && (grant_id == ID_W'(i));
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) sel_word = bus.req_data[i*D_W +: D_W];
    end
  end

  assign load          = !out_valid_q || bus.out_ready;
  assign accept        = grant_any && load;
  assign bus.req_ready = grant & {NUM_REQ{load & rst_n}};

`ifdef POSIT_DENORM_ARB_BURST_LOCK_EN
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] lock_id;
  logic [ID_W-1:0] lock_id_nxt;
  logic            sel_last;

  always_comb begin
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) sel_last = bus.req_last[i];
    end
  end

  // While locked, only the burst owner may win, even if it drops valid.
  always_comb begin
    eligible = bus.req_valid;
    if (state == ST_LOCKED) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (lock_id != ID_W'(i)) eligible[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      lock_id <= '0;
    end else begin
      state   <= state_nxt;
      lock_id <= lock_id_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    if (accept) begin
      if (sel_last) begin
        state_nxt = ST_IDLE;
      end else begin
        state_nxt   = ST_LOCKED;
        lock_id_nxt = grant_id;
      end
    end
  end

  // The pointer only moves when a burst (or single beat) completes.
  assign ptr_adv = accept && sel_last;
`else
  logic unused_last;
  assign unused_last = ^bus.req_last;
  assign eligible    = bus.req_valid;
  assign ptr_adv     = accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      if (ptr_adv) rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
      if (load) begin
        out_valid_q <= grant_any;
        if (grant_any) begin
          out_data_q <= canon(sel_word);
          out_id_q   <= grant_id;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
endmodule
`default_nettype wire

// File: tb/tb_posit_denorm_arbiter.sv
`default_nettype none
// Bench for posit_denorm_arbiter: canonicalization vector table, directed
// corner sequences and random traffic checked against a behavioural model.
module tb_posit_denorm_arbiter;
  localparam int N   = 4;
  localparam int D_W = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  posit_denorm_arbiter_if #(.NUM_REQ(N)) bus ();
  posit_denorm_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  posit_denorm_arbiter_if #(.NUM_REQ(2)) bus2 ();
  posit_denorm_arbiter #(.NUM_REQ(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  int total = 0;
  int bad   = 0;

  logic [N-1:0]   rv;
  logic [N-1:0]   rl;
  logic           ordy;
  logic [D_W-1:0] wd [N];

  bit             m_valid;
  logic [D_W-1:0] m_data;
  int             m_id;
  int             m_ptr;
  bit             m_lock;
  int             m_lock_id;

  typedef struct {
    logic [D_W-1:0] in_w;
    logic [D_W-1:0] exp_w;
  } cvec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [D_W-1:0] canon_ref(input logic [D_W-1:0] w);
    if (w[D_W-2]) return D_W'(1) << (D_W - 2);
    if (w[D_W-3]) return D_W'(1) << (D_W - 3);
    return w;
  endfunction

  function automatic int pick();
    if (m_lock) return rv[m_lock_id] ? m_lock_id : -1;
    for (int k = 0; k < N; k++) begin
      if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid   = 1'b0;
    m_data    = '0;
    m_id      = 0;
    m_ptr     = 0;
    m_lock    = 1'b0;
    m_lock_id = 0;
  endtask

  task automatic advance(input int g);
`ifdef POSIT_DENORM_ARB_BURST_LOCK_EN
    if (!rl[g]) begin
      m_lock    = 1'b1;
      m_lock_id = g;
    end else begin
      m_lock = 1'b0;
      m_ptr  = (g + 1) % N;
    end
`else
    m_ptr = (g + 1) % N;
`endif
  endtask

  task automatic drive();
    bus.req_valid = rv;
    bus.req_last  = rl;
    bus.out_ready = ordy;
    for (int i = 0; i < N; i++) bus.req_data[i*D_W +: D_W] = wd[i];
  endtask

  // One clock: check ready before the edge, then the output register after it.
  task automatic step(input string tag, output int acc);
    int             g;
    bit             load;
    logic [N-1:0]   exp_rdy;
    drive();
    #1;
    load    = !m_valid || ordy;
    g       = pick();
    exp_rdy = '0;
    acc     = -1;
    if (g >= 0 && load) begin
      exp_rdy[g] = 1'b1;
      acc        = g;
    end
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (load) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_id   = g;
        m_data = canon_ref(wd[g]);
        advance(g);
      end
    end
    #1;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".out_data"}, 32'(bus.out_data), 32'(m_data));
    chk({tag, ".out_id"}, 32'(bus.out_id), 32'(m_id));
  endtask

  initial begin
    int    acc;
    int    exp_ids [8];
    cvec_t cv [5];

    exp_ids = '{0, 1, 2, 3, 0, 1, 2, 3};
    cv[0] = '{in_w: 12'hEA3, exp_w: 12'h400};
    cv[1] = '{in_w: 12'hA67, exp_w: 12'h200};
    cv[2] = '{in_w: 12'h0B5, exp_w: 12'h0B5};
    cv[3] = '{in_w: 12'h9C1, exp_w: 12'h9C1};
    cv[4] = '{in_w: 12'h420, exp_w: 12'h400};

    rv   = '1;
    rl   = '1;
    ordy = 1'b1;
    for (int i = 0; i < N; i++) wd[i] = D_W'($urandom);
    bus2.req_valid = '0;
    bus2.req_last  = '1;
    bus2.req_data  = '0;
    bus2.out_ready = 1'b1;
    drive();
    model_reset();

    // Reset state, with every requester valid.
    @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out_data", 32'(bus.out_data), 32'd0);
    chk("rst.out_id", 32'(bus.out_id), 32'd0);
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rr.pre_valid", 32'(bus.out_valid), 32'd0);

    // Round robin over four continuous requesters.
    for (int i = 0; i < 8; i++) begin
      rv = 4'b1111;
      step("rr", acc);
      chk($sformatf("rr.id[%0d]", i), 32'(bus.out_id), 32'(exp_ids[i]));
    end

    // Backpressure on a lone requester 2.
    rv    = 4'b0100;
    wd[2] = 12'h0B5;
    step("bp.first", acc);
    chk("bp.first_acc", 32'(acc), 32'd2);
    ordy  = 1'b0;
    wd[2] = 12'h9C1;
    for (int i = 0; i < 3; i++) begin
      step("bp.hold", acc);
      chk("bp.hold_id", 32'(bus.out_id), 32'd2);
      chk("bp.hold_data", 32'(bus.out_data), 32'h0B5);
    end
    ordy = 1'b1;
    step("bp.release", acc);
    chk("bp.release_acc", 32'(acc), 32'd2);

    // Canonicalization vectors through requester 0.
    for (int i = 0; i < 5; i++) begin
      rv    = 4'b0001;
      wd[0] = cv[i].in_w;
      step("canon", acc);
      chk($sformatf("canon[%0d]", i), 32'(bus.out_data), 32'(cv[i].exp_w));
    end

    // Asynchronous reset while the output register holds a word.
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst.out_id", 32'(bus.out_id), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rv    = 4'b1010;
    step("arst.after", acc);
    chk("arst.first_grant", 32'(acc), 32'd1);

    // Random traffic with backpressure.
    rv = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 1) == 1) begin
          rv[i] = 1'b1;
          wd[i] = D_W'($urandom);
          rl[i] = ($urandom_range(0, 3) != 0);
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      step("rand", acc);
      if (acc >= 0) rv[acc] = 1'b0;
    end

`ifdef POSIT_DENORM_ARB_BURST_LOCK_EN
    rst_n = 1'b0;
    rv    = '0;
    ordy  = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      logic [N-1:0] b_rv [6];
      logic [N-1:0] b_rl [6];
      int           b_acc [6];
      b_rv  = '{4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b0011, 4'b0001};
      b_rl  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0001};
      b_acc = '{0, 1, -1, 1, 1, 0};
      for (int i = 0; i < 6; i++) begin
        rv = b_rv[i];
        rl = b_rl[i];
        step("burst", acc);
        chk($sformatf("burst.acc[%0d]", i), 32'(acc), 32'(b_acc[i]));
      end
    end
`endif

    // Two-requester instance alternates.
    bus2.req_valid = 2'b11;
    bus2.req_data  = {12'h0B5, 12'h9C1};
    for (int b = 0; b < 6; b++) begin
      @(posedge clk);
      #1;
      chk($sformatf("n2.id[%0d]", b), 32'(bus2.out_id), 32'(b % 2));
      chk($sformatf("n2.valid[%0d]", b), 32'(bus2.out_valid), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
